led_blink_axil_slave: RTL
=========================

LED_BLINK_AXIL_SLAVE -- requirements
Module: led_blink_axil_slave

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width; only 32 is supported.
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, byte-address width covering 4 word registers.
REQ-003 SHALL have parameter LED_WIDTH, default 4, number of LED outputs (1..8).
REQ-004 SHALL have port s00_axi_aclk, input, 1, sole clock; all logic rising-edge.
REQ-005 SHALL have port s00_axi_aresetn, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have ports s00_axi_awaddr (in, ADDR_WIDTH), s00_axi_awprot (in, 3, ignored), s00_axi_awvalid (in, 1) and s00_axi_awready (out, 1).
REQ-007 SHALL have ports s00_axi_wdata (in, 32), s00_axi_wstrb (in, 4), s00_axi_wvalid (in, 1) and s00_axi_wready (out, 1).
REQ-008 SHALL have ports s00_axi_bresp (out, 2), s00_axi_bvalid (out, 1) and s00_axi_bready (in, 1).
REQ-009 SHALL have ports s00_axi_araddr (in, ADDR_WIDTH), s00_axi_arprot (in, 3, ignored), s00_axi_arvalid (in, 1) and s00_axi_arready (out, 1).
REQ-010 SHALL have ports s00_axi_rdata (out, 32), s00_axi_rresp (out, 2), s00_axi_rvalid (out, 1) and s00_axi_rready (in, 1).
REQ-011 SHALL have port led_o, output, LED_WIDTH, LED drive.

Function
REQ-012 Register map (word index = addr[3:2]; addr[1:0] ignored):
- 0x0 CTRL: bit0 enable, bit1 blink; other bits read 0.
- 0x4 PATTERN: bits[LED_WIDTH-1:0] stored; upper bits read 0.
- 0x8 PERIOD: 32-bit half-period in clocks.
- 0xC STATUS: read-only; bit0 phase, bits[15:8] led_o zero-extended.
REQ-013 Write channel: AW and W SHALL be accepted independently in any order; each ready is high for exactly one cycle per accepted beat; an accepted address or data beat is held until its partner arrives.
REQ-014 Once both are held and bvalid=0, the register update and bvalid=1 SHALL occur on the next edge; bvalid holds until bready=1.
REQ-015 awready/wready SHALL stay low while bvalid=1 or a beat of the same channel is already held, so at most one write is outstanding.
REQ-016 wstrb[n] SHALL gate byte n of the register update; wstrb=0 updates nothing but still responds.
REQ-017 Writes to STATUS SHALL be ignored; bresp SHALL always be OKAY (2'b00).
REQ-018 Read: arready SHALL pulse one cycle when arvalid=1 and rvalid=0; rdata and rvalid=1 are driven the following cycle and held until rready=1; rresp is always OKAY.
REQ-019 Simultaneous read and write SHALL proceed concurrently; a read in the same cycle as a write update returns the pre-write value.
REQ-020 Blink engine: 32-bit counter increments when enable=1 and blink=1; when counter reaches PERIOD-1, counter clears and phase toggles; PERIOD=0 is treated as 1 (phase toggles every cycle).
REQ-021 A write to PERIOD or CTRL SHALL clear counter to 0; clearing enable or blink SHALL also clear phase to 0.
REQ-022 led_o SHALL be registered (1-cycle latency):
- 0 when enable=0;
- PATTERN when enable=1 and blink=0;
- PATTERN when blink=1 and phase=0, else 0.

Reset
REQ-023 While s00_axi_aresetn=0 all ready/valid outputs, rdata, bresp, rresp, led_o, CTRL, PATTERN, counter and phase SHALL be 0, and PERIOD SHALL be 32'd50_000_000.
REQ-024 Reset mid-transaction SHALL drop held beats and pending responses with no register update.

Verification
REQ-025 Write 0x1,0x2,0x3 to 0x0/0x4/0x8 then read all four -> 0x1, 0x2, 0x3 and STATUS=0x00000200 (led_o=PATTERN=0x2 after 1 cycle).
REQ-026 Present W two cycles before AW -> single bvalid, register updated once, bresp=0.
REQ-027 Write PATTERN 0xFFFFFFFF with wstrb=4'b0000, then 4'b0001 -> reads 0x0 then 0xF.
REQ-028 CTRL=0x3, PERIOD=4, PATTERN=0xA -> led_o alternates 0xA/0x0 every 4 clocks; STATUS bit0 tracks phase.
REQ-029 Hold bready=0 for 10 cycles after write; issue read meanwhile -> awready stays 0, read completes normally.
REQ-030 Assert reset during pending bvalid -> all outputs 0 asynchronously, PERIOD reads 0x02FAF080 after release.

Source files
------------

// File: rtl/led_blink_axil_slave.sv
// AXI4-Lite slave with four word registers driving a blinking LED bank.
// CTRL/PATTERN/PERIOD are writable; STATUS exposes phase and LED state.
module led_blink_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int LED_WIDTH          = 4
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    output logic [LED_WIDTH-1:0]            led_o
);

    localparam logic [31:0] PERIOD_RST = 32'd50_000_000;

    logic                 r_awready, r_wready, r_bvalid;
    logic                 r_arready, r_rvalid;
    logic [31:0]          r_rdata;
    logic                 r_aw_held, r_w_held;
    logic [1:0]           r_aw_idx;
    logic [31:0]          r_wdata;
    logic [3:0]           r_wstrb;
    logic [1:0]           r_ctrl;
    logic [LED_WIDTH-1:0] r_pattern;
    logic [31:0]          r_period;
    logic [31:0]          r_cnt;
    logic                 r_phase;
    logic [LED_WIDTH-1:0] r_led;

    logic        w_wr_fire;
    logic [31:0] w_wr_old, w_wr_val, w_pat32, w_rd_mux, w_per_m1;
    logic [7:0]  w_led8;
    logic [1:0]  w_ctrl_nxt;
    logic        w_unused;

    function automatic logic [31:0] f_merge(input logic [31:0] i_old,
                                            input logic [31:0] i_new,
                                            input logic [3:0]  i_strb);
        logic [31:0] v;
        v = i_old;
        for (int b = 0; b < 4; b++)
            if (i_strb[b]) v[8*b +: 8] = i_new[8*b +: 8];
        return v;
    endfunction

    assign s00_axi_awready = r_awready;
    assign s00_axi_wready  = r_wready;
    assign s00_axi_bvalid  = r_bvalid;
    assign s00_axi_bresp   = 2'b00;
    assign s00_axi_arready = r_arready;
    assign s00_axi_rvalid  = r_rvalid;
    assign s00_axi_rdata   = r_rdata;
    assign s00_axi_rresp   = 2'b00;
    assign led_o           = r_led;

    assign w_unused = ^{s00_axi_awprot, s00_axi_arprot,
                        s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    assign w_wr_fire  = r_aw_held && r_w_held && !r_bvalid;
    assign w_wr_val   = f_merge(w_wr_old, r_wdata, r_wstrb);
    assign w_ctrl_nxt = (w_wr_fire && r_aw_idx == 2'd0) ? w_wr_val[1:0] : r_ctrl;
    assign w_per_m1   = (r_period == 32'd0) ? 32'd0 : r_period - 32'd1;

    // Zero-extended views and register muxes for write-merge and read-back
    always_comb begin
        w_led8 = '0;
        w_led8[LED_WIDTH-1:0] = r_led;
        w_pat32 = '0;
        w_pat32[LED_WIDTH-1:0] = r_pattern;
        w_wr_old = '0;
        case (r_aw_idx)
            2'd0:    w_wr_old = {30'd0, r_ctrl};
            2'd1:    w_wr_old = w_pat32;
            2'd2:    w_wr_old = r_period;
            default: w_wr_old = '0;
        endcase
        w_rd_mux = '0;
        case (s00_axi_araddr[3:2])
            2'd0:    w_rd_mux = {30'd0, r_ctrl};
            2'd1:    w_rd_mux = w_pat32;
            2'd2:    w_rd_mux = r_period;
            default: w_rd_mux = {16'd0, w_led8, 7'd0, r_phase};
        endcase
    end

    // Write address: one-cycle ready pulse, hold the word index until used
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_awready <= 1'b0;
            r_aw_held <= 1'b0;
            r_aw_idx  <= 2'd0;
        end else begin
            r_awready <= 1'b0;
            if (s00_axi_awvalid && r_awready) begin
                r_aw_held <= 1'b1;
                r_aw_idx  <= s00_axi_awaddr[3:2];
            end else if (s00_axi_awvalid && !r_aw_held && !r_bvalid) begin
                r_awready <= 1'b1;
            end
            if (w_wr_fire) r_aw_held <= 1'b0;
        end
    end

    // Write data: one-cycle ready pulse, hold data and strobes until used
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_wready <= 1'b0;
            r_w_held <= 1'b0;
            r_wdata  <= 32'd0;
            r_wstrb  <= 4'd0;
        end else begin
            r_wready <= 1'b0;
            if (s00_axi_wvalid && r_wready) begin
                r_w_held <= 1'b1;
                r_wdata  <= s00_axi_wdata;
                r_wstrb  <= s00_axi_wstrb;
            end else if (s00_axi_wvalid && !r_w_held && !r_bvalid) begin
                r_wready <= 1'b1;
            end
            if (w_wr_fire) r_w_held <= 1'b0;
        end
    end

    // Register update and write response once both beats are held
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_bvalid  <= 1'b0;
            r_ctrl    <= 2'd0;
            r_pattern <= '0;
            r_period  <= PERIOD_RST;
        end else if (w_wr_fire) begin
            r_bvalid <= 1'b1;
            case (r_aw_idx)
                2'd0:    r_ctrl    <= w_wr_val[1:0];
                2'd1:    r_pattern <= w_wr_val[LED_WIDTH-1:0];
                2'd2:    r_period  <= w_wr_val;
                default: ;
            endcase
        end else if (r_bvalid && s00_axi_bready) begin
            r_bvalid <= 1'b0;
        end
    end

    // Read channel: capture pre-update register value at the handshake
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= 32'd0;
        end else begin
            r_arready <= 1'b0;
            if (s00_axi_arvalid && r_arready) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_mux;
            end else if (s00_axi_arvalid && !r_rvalid) begin
                r_arready <= 1'b1;
            end
            if (r_rvalid && s00_axi_rready) r_rvalid <= 1'b0;
        end
    end

    // Blink engine: half-period counter and phase toggle
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_cnt   <= 32'd0;
            r_phase <= 1'b0;
        end else if (!(w_ctrl_nxt[0] && w_ctrl_nxt[1])) begin
            r_cnt   <= 32'd0;
            r_phase <= 1'b0;
        end else if (w_wr_fire && (r_aw_idx == 2'd0 || r_aw_idx == 2'd2)) begin
            r_cnt <= 32'd0;
        end else if (r_cnt >= w_per_m1) begin
            r_cnt   <= 32'd0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt <= r_cnt + 32'd1;
        end
    end

    // Registered LED drive
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_led <= '0;
        end else if (!r_ctrl[0] || (r_ctrl[1] && r_phase)) begin
            r_led <= '0;
        end else begin
            r_led <= r_pattern;
        end
    end

endmodule
